timer_ctrl_master: RTL and testbench



---
 rtl/timer_ctrl_master_if.sv | 37 +++
 rtl/timer_ctrl_master.sv | 226 ++++++++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_master_if.sv
// rtl/timer_ctrl_master_if.sv - Avalon-MM bus between the sequencer and the interval-timer s1 slave
//
// Signals:
//   tmr_address    3   register address (0 status, 1 control, 2/3 period, 4/5 snapshot)
//   tmr_chipselect 1   slave select, one cycle per bus access
//   tmr_write_n    1   active-low write strobe
//   tmr_writedata  16  write data
//   tmr_readdata   16  read data, valid the cycle after the read address is presented
//   tmr_irq        1   timeout interrupt, held until the status register is written
// Modports: master (sequencer side), slave (timer side).

interface timer_ctrl_master_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_ctrl_master.sv
// rtl/timer_ctrl_master.sv - Avalon-MM master that programs and services the 16-bit interval timer
//
// Programs the timer period, starts it in one-shot or continuous mode, clears
// each timeout interrupt and counts it, stops it on request and performs
// snapshot reads of the running counter.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_start           pulse: program and start (accepted only when idle)
//   cfg_period[31:0]    timer period, latched with an accepted cfg_start
//   cfg_continuous      1 = continuous mode, latched with cfg_period
//   cfg_stop            pulse: stop a running timer (accepted only in RUN)
//   snap_req            pulse: snapshot and read the counter (accepted only in RUN)
//   busy                high whenever the sequencer is not idle
//   cfg_error           one-cycle pulse: cfg_start rejected because period is 0
//   tick_pulse          one-cycle pulse per serviced timeout
//   tick_count          wrapping count of serviced timeouts, cleared only by reset
//   snap_value[31:0]    last snapshot value
//   snap_valid          one-cycle pulse when snap_value is updated
//   tmr                 timer bus, master modport

module timer_ctrl_master #(
    parameter int TICK_W = 16,
    parameter bit ITO_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              cfg_error,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    timer_ctrl_master_if.master tmr
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        GAP,
        WR_CTRL,
        RUN,
        CLR,
        STOP_WR,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_DN
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    state_t      state;
    state_t      state_next;

    logic [15:0] period_hi_q;
    logic        cont_q;
    logic [15:0] snap_lo_q;

    logic        start_ok;
    logic        start_bad;

    logic        cs_d;
    logic        write_n_d;
    logic [2:0]  addr_d;
    logic [15:0] wdata_d;

    assign start_ok  = (state == IDLE) && cfg_start && (cfg_period != 32'd0);
    assign start_bad = (state == IDLE) && cfg_start && (cfg_period == 32'd0);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RUN arbitrates stop over irq over snapshot; anything
    // not accepted in the current state is simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = WR_PL;
            WR_PL:   state_next = WR_PH;
            WR_PH:   state_next = GAP;
            GAP:     state_next = WR_CTRL;
            WR_CTRL: state_next = RUN;
            RUN: begin
                if (cfg_stop) begin
                    state_next = STOP_WR;
                end else if (tmr.tmr_irq) begin
                    state_next = CLR;
                end else if (snap_req) begin
                    state_next = SNAP_WR;
                end
            end
            // One-shot timers stop themselves after the timeout.
            CLR:     state_next = cont_q ? RUN : IDLE;
            STOP_WR: state_next = IDLE;
            SNAP_WR: state_next = SNAP_RL;
            SNAP_RL: state_next = SNAP_RH;
            SNAP_RH: state_next = SNAP_DN;
            SNAP_DN: state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Bus output decode. It looks at the state being entered so that the
    // registered bus signals line up with the state that owns the access.
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = 3'd0;
        wdata_d   = 16'h0000;
        case (state_next)
            WR_PL: begin
                // Only reachable from IDLE, where the period is not yet latched.
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_PERIODL;
                wdata_d   = cfg_period[15:0];
            end
            WR_PH: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_PERIODH;
                wdata_d   = period_hi_q;
            end
            WR_CTRL: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_CONTROL;
                wdata_d   = {12'h000, 1'b0, 1'b1, cont_q, ITO_EN};
            end
            CLR: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_STATUS;
            end
            STOP_WR: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_CONTROL;
                wdata_d   = 16'h0008;
            end
            SNAP_WR: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_SNAPL;
            end
            SNAP_RL: begin
                cs_d   = 1'b1;
                addr_d = ADDR_SNAPL;
            end
            SNAP_RH: begin
                cs_d   = 1'b1;
                addr_d = ADDR_SNAPH;
            end
            default: begin
            end
        endcase
    end

    // Registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_address    <= 3'd0;
            tmr.tmr_writedata  <= 16'h0000;
        end else begin
            tmr.tmr_chipselect <= cs_d;
            tmr.tmr_write_n    <= write_n_d;
            tmr.tmr_address    <= addr_d;
            tmr.tmr_writedata  <= wdata_d;
        end
    end

    // Configuration latch, pulses, tick counter and snapshot capture.
    // Read data arrives one cycle after its address: the low half is on the
    // bus during SNAP_RH, the high half during SNAP_DN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_hi_q <= 16'h0000;
            cont_q      <= 1'b0;
            snap_lo_q   <= 16'h0000;
            cfg_error   <= 1'b0;
            tick_pulse  <= 1'b0;
            tick_count  <= '0;
            snap_value  <= 32'h0000_0000;
            snap_valid  <= 1'b0;
        end else begin
            cfg_error  <= start_bad;
            tick_pulse <= (state == CLR);
            snap_valid <= (state == SNAP_DN);
            if (start_ok) begin
                period_hi_q <= cfg_period[31:16];
                cont_q      <= cfg_continuous;
            end
            if (state == CLR) begin
                tick_count <= tick_count + TICK_W'(1);
            end
            if (state == SNAP_RH) begin
                snap_lo_q <= tmr.tmr_readdata;
            end
            if (state == SNAP_DN) begin
                snap_value <= {tmr.tmr_readdata, snap_lo_q};
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb/tb_timer_ctrl_master.sv - self-checking bench for timer_ctrl_master

module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start;
    logic [31:0] cfg_period;
    logic        cfg_continuous;
    logic        cfg_stop;
    logic        snap_req;

    logic        busy, cfg_error, tick_pulse, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        busy2, cfg_error2, tick_pulse2, snap_valid2;
    logic [2:0]  tick_count2;
    logic [31:0] snap_value2;

    timer_ctrl_master_if bus ();
    timer_ctrl_master_if bus2 ();

    always #5 clk = ~clk;

    // Timer slave model: registered read data, irq pending until status write.
    logic [15:0] rdata = 16'h0000;
    logic [15:0] slave_lo = 16'h0000;
    logic [15:0] slave_hi = 16'h0000;
    int          irq_raise = 0;
    int          irq_clr = 0;
    logic        irq_line;

    assign irq_line           = (irq_raise != irq_clr);
    assign bus.tmr_readdata   = rdata;
    assign bus.tmr_irq        = irq_line;
    assign bus2.tmr_readdata  = rdata;
    assign bus2.tmr_irq       = irq_line;

    always @(posedge clk) begin
        if (bus.tmr_chipselect && bus.tmr_write_n) begin
            rdata <= (bus.tmr_address == 3'd4) ? slave_lo :
                     (bus.tmr_address == 3'd5) ? slave_hi : 16'h0000;
        end
        if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd0) begin
            irq_clr <= irq_clr + 1;
        end
    end

    timer_ctrl_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_stop       (cfg_stop),
        .snap_req       (snap_req),
        .busy           (busy),
        .cfg_error      (cfg_error),
        .tick_pulse     (tick_pulse),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .tmr            (bus)
    );

    // Narrow tick counter instance shares all inputs; exercises counter wrap.
    timer_ctrl_master #(.TICK_W(3)) dut2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_stop       (cfg_stop),
        .snap_req       (snap_req),
        .busy           (busy2),
        .cfg_error      (cfg_error2),
        .tick_pulse     (tick_pulse2),
        .tick_count     (tick_count2),
        .snap_value     (snap_value2),
        .snap_valid     (snap_valid2),
        .tmr            (bus2)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: per-cycle expectations derived from the register protocol.
    typedef struct {
        bit        cs;
        bit        wr;
        bit [2:0]  addr;
        bit [15:0] wdata;
        bit        tick;
        bit        snap;
        bit        err;
        bit        busy;
    } exp_t;

    exp_t        exp_q[$];
    bit          model_busy = 1'b0;
    int unsigned model_count = 0;
    logic [31:0] model_snap = 32'h0;
    bit          run_cmp = 1'b0;

    task automatic push(input bit cs, input bit wr, input bit [2:0] addr, input bit [15:0] wdata,
                        input bit tick, input bit snap, input bit err, input bit bz);
        exp_t e;
        e.cs = cs; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.tick = tick; e.snap = snap; e.err = err; e.busy = bz;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (run_cmp && reset_n) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e.cs = 0; e.wr = 0; e.addr = 0; e.wdata = 0;
                e.tick = 0; e.snap = 0; e.err = 0; e.busy = model_busy;
            end
            if (e.tick) model_count = model_count + 1;
            if (e.snap) model_snap = {slave_hi, slave_lo};
            chk("chipselect", 32'(bus.tmr_chipselect), 32'(e.cs));
            chk("write_n", 32'(bus.tmr_write_n), (e.cs && e.wr) ? 32'd0 : 32'd1);
            if (e.cs) chk("address", 32'(bus.tmr_address), 32'(e.addr));
            if (e.cs && e.wr) chk("writedata", 32'(bus.tmr_writedata), 32'(e.wdata));
            chk("tick_pulse", 32'(tick_pulse), 32'(e.tick));
            chk("snap_valid", 32'(snap_valid), 32'(e.snap));
            chk("cfg_error", 32'(cfg_error), 32'(e.err));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("tick_count", 32'(tick_count), model_count & 32'hFFFF);
            chk("snap_value", snap_value, model_snap);
            chk("tick_count_w3", 32'(tick_count2), model_count & 32'h7);
            chk("tick_pulse_w3", 32'(tick_pulse2), 32'(e.tick));
            chk("busy_w3", 32'(busy2), 32'(e.busy));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("drain", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic start_timer(input logic [31:0] p, input bit c);
        cfg_period     = p;
        cfg_continuous = c;
        cfg_start      = 1'b1;
        if (p == 32'd0) begin
            push(0, 0, 0, 0, 0, 0, 1, 0);
        end else begin
            push(1, 1, 3'd2, p[15:0], 0, 0, 0, 1);
            push(1, 1, 3'd3, p[31:16], 0, 0, 0, 1);
            push(0, 0, 0, 0, 0, 0, 0, 1);
            push(1, 1, 3'd1, 16'(4 + 2 * c + 1), 0, 0, 0, 1);
            model_busy = 1'b1;
        end
        step();
        cfg_start = 1'b0;
    endtask

    task automatic fire_irq(input bit c);
        irq_raise = irq_raise + 1;
        push(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1);
        push(0, 0, 0, 0, 1, 0, 0, c);
        model_busy = c;
        drain();
    endtask

    task automatic snapshot(input logic [15:0] lo, input logic [15:0] hi);
        slave_lo = lo;
        slave_hi = hi;
        snap_req = 1'b1;
        push(1, 1, 3'd4, 16'h0000, 0, 0, 0, 1);
        push(1, 0, 3'd4, 16'h0000, 0, 0, 0, 1);
        push(1, 0, 3'd5, 16'h0000, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 1, 0, 1);
        step();
        snap_req = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; cfg_start = 0; cfg_period = 0; cfg_continuous = 0;
        cfg_stop = 0; snap_req = 0;
        repeat (3) @(negedge clk);
        chk("rst_chipselect", 32'(bus.tmr_chipselect), 32'd0);
        chk("rst_write_n", 32'(bus.tmr_write_n), 32'd1);
        chk("rst_address", 32'(bus.tmr_address), 32'd0);
        chk("rst_writedata", 32'(bus.tmr_writedata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick_count", 32'(tick_count), 32'd0);
        chk("rst_snap_value", snap_value, 32'd0);
        chk("rst_pulses", {29'd0, tick_pulse, snap_valid, cfg_error}, 32'd0);
        #1;
        reset_n = 1'b1;
        run_cmp = 1'b1;
        step();

        // Program period 0x10, continuous; a second cfg_start while busy is dropped.
        start_timer(32'h0000_0010, 1'b1);
        chk("lit_wr_pl", {13'd0, bus.tmr_address, bus.tmr_writedata}, {13'd0, 3'd2, 16'h0010});
        chk("lit_busy_after_start", 32'(busy), 32'd1);
        cfg_period = 32'd0;
        cfg_start  = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("lit_wr_ph", {13'd0, bus.tmr_address, bus.tmr_writedata}, {13'd0, 3'd3, 16'h0000});
        step();
        chk("lit_gap_cs", 32'(bus.tmr_chipselect), 32'd0);
        step();
        chk("lit_wr_ctrl", {13'd0, bus.tmr_address, bus.tmr_writedata}, {13'd0, 3'd1, 16'h0007});
        drain();

        // Three serviced timeouts, then six more to carry the 3-bit counter past wrap.
        repeat (3) fire_irq(1'b1);
        chk("lit_tick_count_3", 32'(tick_count), 32'd3);
        repeat (6) fire_irq(1'b1);
        chk("lit_tick_count_9", 32'(tick_count), 32'd9);
        chk("lit_tick_count_w3_wrap", 32'(tick_count2), 32'd1);

        // Snapshots; cfg_start in RUN is ignored.
        snapshot(16'h1234, 16'h0001);
        chk("lit_snap_value", snap_value, 32'h0001_1234);
        cfg_period = 32'd3;
        cfg_start  = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        snapshot(16'hBEEF, 16'hCAFE);

        // Stop, then requests in IDLE are dropped.
        cfg_stop = 1'b1;
        push(1, 1, 3'd1, 16'h0008, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        model_busy = 1'b0;
        step();
        cfg_stop = 1'b0;
        drain();
        cfg_stop = 1'b1; snap_req = 1'b1;
        step();
        cfg_stop = 1'b0; snap_req = 1'b0;
        repeat (3) step();

        // Zero period is rejected.
        start_timer(32'd0, 1'b1);
        drain();
        chk("lit_err_busy", 32'(busy), 32'd0);

        // One-shot: single service then IDLE; later stop is ignored.
        start_timer(32'h0001_0005, 1'b0);
        drain();
        fire_irq(1'b0);
        chk("lit_oneshot_busy", 32'(busy), 32'd0);
        chk("lit_oneshot_count", 32'(tick_count), 32'd10);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        repeat (3) step();

        // Stop, irq and snapshot together: stop wins.
        start_timer(32'h0000_0100, 1'b1);
        drain();
        cfg_stop = 1'b1; snap_req = 1'b1;
        irq_raise = irq_raise + 1;
        push(1, 1, 3'd1, 16'h0008, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        model_busy = 1'b0;
        step();
        cfg_stop = 1'b0; snap_req = 1'b0;
        drain();
        chk("lit_conflict_count", 32'(tick_count), 32'd10);

        // Reset in the middle of WR_PH.
        start_timer(32'h0002_0020, 1'b1);
        step();
        chk("lit_pre_reset_addr", 32'(bus.tmr_address), 32'd3);
        reset_n = 1'b0;
        exp_q.delete();
        model_busy  = 1'b0;
        model_count = 0;
        model_snap  = 32'h0;
        #1;
        chk("lit_reset_cs", 32'(bus.tmr_chipselect), 32'd0);
        chk("lit_reset_write_n", 32'(bus.tmr_write_n), 32'd1);
        chk("lit_reset_busy", 32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("lit_reset_count", 32'(tick_count), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
